// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - word-addressed synchronous RAM with request detect, optional wait states (MEM_WAIT_EN)
module memory_unit #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] MDRdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              MemBusy,
  output logic              MemDone
);

`ifdef MEM_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [CNT_W-1:0] cnt;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;

  // Wait states are compiled out; keep the parameter referenced.
  logic cfg_unused;
  assign cfg_unused = (WAIT_CYCLES != 0);
`endif

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  state_t            state, next_state;
  logic              read_q, write_q;
  logic              read_rise, write_rise;
  logic              accept, enter_done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_wr;

  // A request is a strobe seen high while its delayed copy is still low.
  assign read_rise  = Read & ~read_q;
  assign write_rise = Write & ~write_q;

  // Next-state logic; accept only from IDLE, read wins over a simultaneous write.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (read_rise || write_rise) begin
          accept = 1'b1;
`ifdef MEM_WAIT_EN
          if (WAIT_CYCLES == 0) next_state = S_DONE;
          else                  next_state = S_WAIT;
`else
          next_state = S_DONE;
`endif
        end
      end
`ifdef MEM_WAIT_EN
      S_WAIT: begin
        if (cnt == CNT_W'(1)) next_state = S_DONE;
      end
`endif
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The access completes on the edge that enters DONE; from IDLE the live inputs are the access.
  always_comb begin
    enter_done = (next_state == S_DONE) && (state != S_DONE);
    acc_addr   = addr_q;
    acc_data   = data_q;
    acc_wr     = wr_q;
    if (state == S_IDLE) begin
      acc_addr = Address;
      acc_data = MDRdata;
      acc_wr   = ~read_rise;
    end
  end

  // Control state, strobe history, request latches and read data register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= S_IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      Mdatain <= '0;
    end else begin
      state   <= next_state;
      read_q  <= Read;
      write_q <= Write;
      if (accept) begin
        addr_q <= Address;
        data_q <= MDRdata;
        wr_q   <= ~read_rise;
      end
      if (enter_done && !acc_wr) Mdatain <= mem[acc_addr];
    end
  end

`ifdef MEM_WAIT_EN
  // Wait-state counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(WAIT_CYCLES);
    end else if (state == S_WAIT) begin
      cnt <= cnt - CNT_W'(1);
    end
  end
`endif

  // Array write; contents survive reset, so no reset term here.
  always_ff @(posedge clock) begin
    if (enter_done && acc_wr) mem[acc_addr] <= acc_data;
  end

  assign MemBusy = (state != S_IDLE);
  assign MemDone = (state == S_DONE);

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - self-checking bench for memory_unit against a word-array reference model
module tb_memory_unit;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int W  = 2;
`ifdef MEM_WAIT_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = 1;
`endif

  logic          clock = 1'b0;
  logic          clear;
  logic          Read, Write;
  logic [AW-1:0] Address;
  logic [DW-1:0] MDRdata;
  logic [DW-1:0] Mdatain;
  logic          MemBusy, MemDone;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] model [0:(1<<AW)-1];
  logic [DW-1:0] mdat;
  logic [AW-1:0] pool [8];

  memory_unit #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clock(clock), .clear(clear), .Read(Read), .Write(Write),
    .Address(Address), .MDRdata(MDRdata), .Mdatain(Mdatain),
    .MemBusy(MemBusy), .MemDone(MemDone)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with strobes already driven; follows one access to completion.
  task automatic track(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input string tag);
    logic [DW-1:0] old_m, new_m;
    old_m = mdat;
    if (rd) new_m = model[a];
    else begin
      new_m = old_m;
      if (wr) model[a] = d;
    end
    for (int k = 0; k <= LAT; k++) begin
      @(posedge clock); #1;
      chk($sformatf("%s_busy%0d", tag, k), DW'(MemBusy), DW'(k < LAT));
      chk($sformatf("%s_done%0d", tag, k), DW'(MemDone), DW'(k == LAT - 1));
      chk($sformatf("%s_mdat%0d", tag, k), Mdatain, (k >= LAT - 1) ? new_m : old_m);
      @(negedge clock);
      if (k == 0) begin
        Read  = 1'b0;
        Write = 1'b0;
      end
    end
    mdat = new_m;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
    Read = rd; Write = wr; Address = a; MDRdata = d;
    track(rd, wr, a, d, tag);
  endtask

  initial begin
    int dones;
    clear = 1'b0; Read = 1'b0; Write = 1'b0; Address = '0; MDRdata = '0;
    mdat = '0;
    pool[0] = 9'h000; pool[1] = 9'h012; pool[2] = 9'h014; pool[3] = 9'h018;
    pool[4] = 9'h020; pool[5] = 9'h1FF; pool[6] = 9'h100; pool[7] = 9'h0AB;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", DW'(MemBusy), '0);
    chk("rst_done", DW'(MemDone), '0);
    chk("rst_mdat", Mdatain, '0);
    clear = 1'b1;
    @(negedge clock);

    // Preload each pool location with its own address
    for (int i = 0; i < 8; i++) access(1'b0, 1'b1, pool[i], DW'(pool[i]), "pre");

    // Write then read
    access(1'b0, 1'b1, 9'h000, 32'h28918000, "wr0");
    access(1'b1, 1'b0, 9'h000, 32'h0, "rd0");

    // Held strobe: exactly one completion
    Read = 1'b1; Address = 9'h012; dones = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clock); #1;
      if (MemDone) dones++;
      @(negedge clock);
      if (c == 9) Read = 1'b0;
    end
    mdat = model[9'h012];
    chk("hold_pulses", DW'(dones), DW'(1));
    chk("hold_mdat", Mdatain, mdat);

    // Write arriving while busy is lost
    Read = 1'b1; Address = 9'h014; dones = 0;
    @(posedge clock); #1;
    if (MemDone) dones++;
    @(negedge clock);
    Read = 1'b0; Write = 1'b1; MDRdata = 32'hFFFFFFFF;
    for (int c = 0; c < LAT + 3; c++) begin
      @(posedge clock); #1;
      if (MemDone) dones++;
      @(negedge clock);
      if (c == 0) Write = 1'b0;
    end
    mdat = model[9'h014];
    chk("busy_pulses", DW'(dones), DW'(1));
    chk("busy_mdat", Mdatain, 32'h00000014);
    access(1'b1, 1'b0, 9'h014, 32'h0, "busy_rd");

    // Simultaneous strobes: read serviced, write dropped
    access(1'b1, 1'b1, 9'h018, 32'hDEADBEEF, "sim");
    chk("sim_val", mdat, 32'h00000018);
    access(1'b1, 1'b0, 9'h018, 32'h0, "sim_rd");

    // Reset in the middle of a write
    Write = 1'b1; Address = 9'h020; MDRdata = 32'hAAAA5555;
    @(posedge clock); #3;
    clear = 1'b0; #1;
    chk("mid_busy", DW'(MemBusy), '0);
    chk("mid_done", DW'(MemDone), '0);
    chk("mid_mdat", Mdatain, '0);
    mdat = '0;
    if (LAT == 1) model[9'h020] = 32'hAAAA5555;
    @(negedge clock);
    Write = 1'b0; Read = 1'b1; Address = 9'h014;
    @(posedge clock); #1;
    chk("held_busy", DW'(MemBusy), '0);
    @(negedge clock);
    // Strobe already high as reset releases counts as a request
    clear = 1'b1;
    track(1'b1, 1'b0, 9'h014, 32'h0, "rel");
    access(1'b1, 1'b0, 9'h020, 32'h0, "mid_rd");

    // Random accesses against the model
    for (int i = 0; i < 40; i++) begin
      bit rd;
      logic [AW-1:0] a;
      rd = 1'($urandom_range(0, 1));
      a  = pool[$urandom_range(0, 7)];
      access(rd, ~rd, a, $urandom, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
